// File: rtl/phase_sequencer_pkg.sv
// phase_sequencer_pkg: shared phase constants and sequencer state encoding
package phase_sequencer_pkg;
  localparam logic [2:0] PHASE_IDLE  = 3'd0;
  localparam logic [2:0] PHASE_FIRST = 3'd1;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;
endpackage

// File: rtl/phase_sequencer_edge_sync.sv
// edge_sync: synchronizes an async button and emits a one-cycle registered rising-edge pulse
module edge_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic pulse
);
  logic [STAGES-1:0] sync;
  logic [STAGES-1:0] valid;
  logic prev;
  // valid tracks when the chain holds real samples, so a button held through reset never looks like a fresh press
  always_ff @(posedge clk) begin
    if (rst) begin
      sync  <= '0;
      valid <= '0;
      prev  <= 1'b1;
      pulse <= 1'b0;
    end else begin
      sync  <= {sync[STAGES-2:0], din};
      valid <= {valid[STAGES-2:0], 1'b1};
      prev  <= valid[STAGES-1] ? sync[STAGES-1] : prev;
      pulse <= valid[STAGES-1] & sync[STAGES-1] & ~prev;
    end
  end
endmodule

// File: rtl/phase_sequencer.sv
// phase_sequencer: run/stop FSM generating instruction phases, stopping only at instruction boundaries
module phase_sequencer
  import phase_sequencer_pkg::*;
#(
  parameter int NUM_PHASES       = 5,
  parameter int EXEC_SYNC_STAGES = 2,
  parameter int INSTR_CNT_W      = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   exec,
  input  logic                   step_mode,
  input  logic                   stop_flag,
  output logic [2:0]             phase,
  output logic                   executing,
  output logic                   halted,
  output logic                   instr_done,
  output logic [INSTR_CNT_W-1:0] instr_count
);
  state_t state, state_n;
  logic [2:0] phase_n;
  logic exec_pulse, stop_req, pause_req, boundary, stop_now, pause_now;
  edge_sync #(.STAGES(EXEC_SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (exec),
    .pulse (exec_pulse)
  );
  assign boundary  = (state == ST_RUN) && (phase == 3'(NUM_PHASES));
  assign stop_now  = stop_req | stop_flag;
  assign pause_now = pause_req | exec_pulse;
  // state, phase, request latches and retired-instruction counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      phase       <= PHASE_IDLE;
      stop_req    <= 1'b0;
      pause_req   <= 1'b0;
      instr_count <= '0;
    end else begin
      state       <= state_n;
      phase       <= phase_n;
      stop_req    <= (state == ST_RUN) && !boundary && stop_now;
      pause_req   <= (state == ST_RUN) && !boundary && pause_now;
      instr_count <= (boundary && !(&instr_count)) ? instr_count + INSTR_CNT_W'(1) : instr_count;
    end
  end
  // next state: start on a press, advance each cycle, decide halt/pause/step/continue at the boundary
  always_comb begin
    state_n = state;
    phase_n = phase;
    if (state != ST_RUN) begin
      state_n = exec_pulse ? ST_RUN : state;
      phase_n = exec_pulse ? PHASE_FIRST : PHASE_IDLE;
    end else if (!boundary) begin
      phase_n = phase + 3'd1;
    end else begin
      state_n = stop_now ? ST_HALT : (pause_now || step_mode) ? ST_IDLE : ST_RUN;
      phase_n = (stop_now || pause_now || step_mode) ? PHASE_IDLE : PHASE_FIRST;
    end
  end
  // status outputs decoded straight from registers
  always_comb begin
    executing  = (state == ST_RUN);
    halted     = (state == ST_HALT);
    instr_done = boundary;
  end
endmodule

// File: tb/tb_phase_sequencer.sv
// tb_phase_sequencer: table vectors, corner-case sequences and random stimulus against a reference model
module tb_phase_sequencer;
  localparam int NP = 5;
  localparam int SS = 2;
  logic clk = 1'b0;
  logic rst, exec, step_mode, stop_flag;
  logic [2:0] phase, phase2;
  logic executing, halted, instr_done, executing2, halted2, instr_done2;
  logic [15:0] instr_count;
  logic [1:0] instr_count2;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int m_phase, m_count, m_count2;
  bit m_halted, m_stop, m_pause;
  bit hist[$];
  typedef struct {
    bit r, x, sm, sf;
    logic [2:0] e_phase;
    bit e_halted;
    logic [15:0] e_count;
  } vec_t;
  vec_t tbl[$];

  always #5 clk = ~clk;

  phase_sequencer dut (
    .clk(clk), .rst(rst), .exec(exec), .step_mode(step_mode), .stop_flag(stop_flag),
    .phase(phase), .executing(executing), .halted(halted), .instr_done(instr_done),
    .instr_count(instr_count)
  );
  phase_sequencer #(.INSTR_CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .exec(exec), .step_mode(step_mode), .stop_flag(stop_flag),
    .phase(phase2), .executing(executing2), .halted(halted2), .instr_done(instr_done2),
    .instr_count(instr_count2)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, act, exp);
    end
  endtask

  // hist holds exec as sampled at each edge since reset; entry 0 stands for "high before reset"
  task automatic model_step(input bit r, input bit x, input bit sm, input bit sf);
    bit p;
    int e;
    if (r) begin
      m_phase = 0; m_count = 0; m_count2 = 0;
      m_halted = 0; m_stop = 0; m_pause = 0;
      hist = {1'b1};
      return;
    end
    e = hist.size() - 1;
    p = (e >= SS + 1) && hist[e-SS] && !hist[e-SS-1];
    if (m_phase == 0) begin
      if (p) begin m_phase = 1; m_halted = 0; end
    end else if (m_phase < NP) begin
      m_stop = m_stop | sf;
      m_pause = m_pause | p;
      m_phase++;
    end else begin
      if (m_count < 65535) m_count++;
      if (m_count2 < 3) m_count2++;
      if (m_stop || sf) begin m_phase = 0; m_halted = 1; end
      else if (m_pause || p || sm) m_phase = 0;
      else m_phase = 1;
      m_stop = 0;
      m_pause = 0;
    end
    hist.push_back(x);
  endtask

  task automatic tick();
    bit r, x, sm, sf;
    r = rst; x = exec; sm = step_mode; sf = stop_flag;
    @(posedge clk);
    #1;
    cyc++;
    model_step(r, x, sm, sf);
    check("model", 64'({phase, executing, halted, instr_done, instr_count, instr_count2,
                        phase2, executing2, halted2, instr_done2}),
          64'({3'(m_phase), m_phase != 0, m_halted, m_phase == NP, 16'(m_count), 2'(m_count2),
               3'(m_phase), m_phase != 0, m_halted, m_phase == NP}));
  endtask

  task automatic wait_phase(input logic [2:0] t, input int max);
    int n = 0;
    do begin
      tick();
      n++;
    end while (phase !== t && n < max);
    check("wait_phase", 64'(phase), 64'(t));
  endtask

  task automatic press();
    exec = 1'b1;
    repeat (3) tick();
    exec = 1'b0;
  endtask

  task automatic add(input bit r, input bit x, input bit sf, input int ph, input bit h, input int c);
    vec_t v;
    v.r = r; v.x = x; v.sm = 1'b0; v.sf = sf;
    v.e_phase = 3'(ph); v.e_halted = h; v.e_count = 16'(c);
    tbl.push_back(v);
  endtask

  initial begin
    rst = 1'b1; exec = 1'b0; step_mode = 1'b0; stop_flag = 1'b0;
    add(1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0);
    add(0, 1, 0, 1, 0, 0);
    add(0, 0, 0, 2, 0, 0);
    add(0, 0, 0, 3, 0, 0);
    add(0, 0, 0, 4, 0, 0);
    add(0, 0, 0, 5, 0, 0);
    add(0, 0, 0, 1, 0, 1);
    add(0, 0, 0, 2, 0, 1);
    add(0, 0, 1, 3, 0, 1);
    add(0, 0, 0, 4, 0, 1);
    add(0, 0, 0, 5, 0, 1);
    add(0, 0, 0, 0, 1, 2);
    add(0, 0, 1, 0, 1, 2);
    add(0, 1, 0, 0, 1, 2);
    add(0, 1, 0, 0, 1, 2);
    add(0, 0, 0, 0, 1, 2);
    add(0, 0, 0, 1, 0, 2);
    add(0, 0, 0, 2, 0, 2);
    foreach (tbl[i]) begin
      rst = tbl[i].r; exec = tbl[i].x; step_mode = tbl[i].sm; stop_flag = tbl[i].sf;
      tick();
      check("tbl_phase", 64'(phase), 64'(tbl[i].e_phase));
      check("tbl_halted", 64'(halted), 64'(tbl[i].e_halted));
      check("tbl_count", 64'(instr_count), 64'(tbl[i].e_count));
    end
    stop_flag = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;
    step_mode = 1'b1;
    repeat (3) tick();
    repeat (3) begin
      press();
      wait_phase(3'd1, 10);
      wait_phase(3'd0, 10);
    end
    check("step_count", 64'(instr_count), 64'd3);
    check("step_idle", 64'(executing), 64'd0);
    step_mode = 1'b0;
    press();
    wait_phase(3'd2, 20);
    exec = 1'b1; tick();
    exec = 1'b0; tick(); tick();
    check("at_boundary", 64'(instr_done), 64'd1);
    stop_flag = 1'b1; tick(); stop_flag = 1'b0;
    check("stop_and_pause_halts", 64'({phase, halted}), 64'({3'd0, 1'b1}));
    stop_flag = 1'b1; repeat (3) tick(); stop_flag = 1'b0;
    check("halt_ignores_stop", 64'({phase, halted}), 64'({3'd0, 1'b1}));
    press();
    wait_phase(3'd3, 20);
    check("restart_clears_halt", 64'(halted), 64'd0);
    rst = 1'b1; tick(); rst = 1'b0;
    check("mid_rst", 64'({phase, instr_count}), 64'd0);
    exec = 1'b1; rst = 1'b1; repeat (2) tick(); rst = 1'b0;
    repeat (10) tick();
    check("held_through_rst", 64'(phase), 64'd0);
    exec = 1'b0; repeat (2) tick();
    press();
    for (int k = 1; k <= 5; k++) begin
      wait_phase(3'd5, 20);
      tick();
      check("sat_count", 64'(instr_count2), 64'(k < 3 ? k : 3));
    end
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 5) == 0) exec = ~exec;
      stop_flag = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 199) == 0) step_mode = ~step_mode;
      tick();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
